// File: rtl/note_phase_acc.sv
// -----------------------------------------------------------------------------
// note_phase_acc
// Fixed-point phase accumulator for wavetable playback. Every processed sample
// tick advances the table index by an integer step (jump) plus a fractional
// step (remainder / MODULUS). An extra index is carried in whenever the
// fractional part overflows, so the pitch does not drift over time.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       level; low forces IDLE and clears phase/frac
//   tick         one-cycle sample strobe
//   jump         integer index step (6 bits)
//   remainder    fractional step numerator over MODULUS (27 bits)
//   phase        registered wavetable index (ADDR_W bits)
//   phase_valid  one-cycle pulse when phase has been updated
//   wrap         one-cycle pulse with phase_valid when the index wrapped
//   mute         registered; high while the latched step is zero
//
// Optional feature macro: NOTE_PHASE_RESET_EN
//   Defined   : a tick whose step differs from the latched step restarts the
//               phase and fraction from 0 before the add.
//   Undefined : phase and fraction stay continuous across step changes.
// -----------------------------------------------------------------------------
module note_phase_acc #(
   parameter int ADDR_W  = 10,
   parameter int MODULUS = 100000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              tick,
   input  logic [5:0]        jump,
   input  logic [26:0]       remainder,
   output logic [ADDR_W-1:0] phase,
   output logic              phase_valid,
   output logic              wrap,
   output logic              mute
);

   localparam logic [26:0] MOD27 = 27'(MODULUS);
   localparam logic [27:0] MOD28 = 28'(MODULUS);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] phase_q, phase_d;
   logic [26:0]       frac_q, frac_d;
   logic              valid_q, valid_d;
   logic              wrap_q, wrap_d;
   logic              mute_q, mute_d;
   logic [5:0]        jump_q, jump_d;
   logic [26:0]       rem_q, rem_d;

   logic [26:0]       rem_sat;
   logic [ADDR_W-1:0] base_phase;
   logic [26:0]       base_frac;
   logic [27:0]       sum;
   logic [26:0]       frac_new;
   logic              carry;
   logic [ADDR_W:0]   add;

   // Datapath for one processed tick: saturate, fractional add, integer add.
   always_comb begin
      // Fractional steps of a full index or more are clamped just below one.
      if (remainder >= MOD27) begin
         rem_sat = MOD27 - 27'd1;
      end else begin
         rem_sat = remainder;
      end

      base_phase = phase_q;
      base_frac  = frac_q;
`ifdef NOTE_PHASE_RESET_EN
      // New note: restart from the top of the table.
      if ({jump, rem_sat} != {jump_q, rem_q}) begin
         base_phase = '0;
         base_frac  = 27'd0;
      end else begin
         base_phase = phase_q;
         base_frac  = frac_q;
      end
`endif

      // Both operands are below MODULUS, so one subtraction normalises.
      sum = {1'b0, base_frac} + {1'b0, rem_sat};
      if (sum >= MOD28) begin
         frac_new = 27'(sum - MOD28);
         carry    = 1'b1;
      end else begin
         frac_new = sum[26:0];
         carry    = 1'b0;
      end

      // The extra top bit of the add is the table wrap indication.
      add = {1'b0, base_phase}
          + {{(ADDR_W-5){1'b0}}, jump}
          + {{ADDR_W{1'b0}}, carry};
   end

   // Next-state logic for the IDLE/RUN controller and all output registers.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      frac_d  = frac_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      mute_d  = mute_q;
      jump_d  = jump_q;
      rem_d   = rem_q;

      case (state_q)
         IDLE: begin
            phase_d = '0;
            frac_d  = 27'd0;
            if (tick && enable) begin
               state_d = RUN;
               phase_d = add[ADDR_W-1:0];
               frac_d  = frac_new;
               valid_d = 1'b1;
               wrap_d  = add[ADDR_W];
               jump_d  = jump;
               rem_d   = rem_sat;
               mute_d  = (jump == 6'd0) && (rem_sat == 27'd0);
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // A tick coinciding with enable falling is dropped.
            if (!enable) begin
               state_d = IDLE;
               phase_d = '0;
               frac_d  = 27'd0;
            end else if (tick) begin
               phase_d = add[ADDR_W-1:0];
               frac_d  = frac_new;
               valid_d = 1'b1;
               wrap_d  = add[ADDR_W];
               jump_d  = jump;
               rem_d   = rem_sat;
               mute_d  = (jump == 6'd0) && (rem_sat == 27'd0);
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
            frac_d  = 27'd0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         frac_q  <= 27'd0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         mute_q  <= 1'b1;
         jump_q  <= 6'd0;
         rem_q   <= 27'd0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         frac_q  <= frac_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         mute_q  <= mute_d;
         jump_q  <= jump_d;
         rem_q   <= rem_d;
      end
   end

   assign phase       = phase_q;
   assign phase_valid = valid_q;
   assign wrap        = wrap_q;
   assign mute        = mute_q;

endmodule

// File: doc/note_phase_acc.md
# note_phase_acc

Fixed-point phase accumulator that sits directly downstream of the note-to-step lookup. Each sample tick it advances a wavetable read index by the integer step `jump` plus a fractional step `remainder / MODULUS`, carrying an extra index whenever the fractional part overflows. The resulting index drives the waveform ROM address, so the audible pitch follows the selected note with no long-term drift.

## Interface
- `ADDR_W`, 10: width of the wavetable index (table length 2^ADDR_W).
- `MODULUS`, 100000000: fractional denominator; `remainder` is expressed in 1/MODULUS units.
- `clk` input, 1: system clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `enable` input, 1: level; low forces IDLE.
- `tick` input, 1: one-cycle sample strobe.
- `jump` input, 6: integer index step.
- `remainder` input, 27: fractional index step, numerator over MODULUS.
- `phase` output, ADDR_W: registered wavetable index.
- `phase_valid` output, 1: one-cycle pulse when `phase` has been updated.
- `wrap` output, 1: one-cycle pulse, coincident with `phase_valid`, when the index wrapped past 2^ADDR_W-1.
- `mute` output, 1: registered; high while the step is zero (silent note).

## Operation
- Reset values: `phase`=0, frac=0, `phase_valid`=0, `wrap`=0, `mute`=1, state=IDLE, latched step=0.
- States:
  - IDLE: phase and frac are held at 0. Leave on the first `tick` with `enable`=1, which enters RUN and processes that tick.
  - RUN: process every tick. When `enable` falls, return to IDLE on the next clock, clearing phase and frac.
- Per processed tick:
  - Sample `jump` and `remainder` into the step registers.
  - Fractional update: sum = frac + remainder, 28-bit.
    - If sum ≥ MODULUS: frac = sum − MODULUS and carry=1.
    - Otherwise: frac = sum and carry=0.
  - Integer update: phase = (phase + jump + carry) mod 2^ADDR_W. `wrap` is the carry-out of this add.
- A `remainder` ≥ MODULUS is saturated to MODULUS−1 before the add.
- `jump`=0 and `remainder`=0: phase and frac are held, `phase_valid` still pulses, and `mute`=1. Any nonzero step sets `mute`=0.
- Step change between ticks: the new step applies from the next tick. Phase is continuous unless the configuration feature is enabled.
- `tick` with `enable`=0: ignored.

## Timing
- Latency: the `phase`, `wrap`, `phase_valid` and `mute` update is visible on the clock edge after the cycle in which `tick` is high (1 cycle).
- Ticks on consecutive cycles are allowed; each tick is processed and throughput is 1 per cycle.
- The step inputs are sampled only in the cycle `tick` is high; they are don't-care otherwise.
- Asserting `rst_n` mid-operation clears everything asynchronously. The first tick after release is processed normally if `enable`=1.
- `enable` falling in the same cycle as `tick`: the tick is ignored, and the next state is IDLE with phase and frac = 0.

## Configuration
- `NOTE_PHASE_RESET_EN`:
  - Defined: a tick whose {`jump`,`remainder`} differs from the latched step clears phase and frac to 0 before the add. The output phase is then exactly `jump` + carry, with carry computed from frac=0.
  - Undefined: a step change keeps phase and frac continuous.
  - Mute transitions follow the same rule.

## Test plan
- Reset: hold `rst_n`=0 -> `phase`=0, `mute`=1, no `phase_valid`. Release with `enable`=0 and 5 ticks -> no change.
- Fractional carry: `jump`=28, `remainder`=16000000, 7 ticks from reset -> phases 28, 56, 84, 112, 140, 168, 197. frac ends at 12000000.
- Wrap: preload phase to 1000 via ticks, then a tick with `jump`=28, `remainder`=0 -> `phase`=4 with `wrap`=1 in the same cycle as `phase_valid`.
- Silent step: `jump`=0, `remainder`=0 after a running note -> `phase` holds, `phase_valid` pulses, `mute`=1. A nonzero step resumes from the held phase with `mute`=0.
- Saturation and back-to-back: `remainder`=134217727 with `jump`=0 on 3 consecutive-cycle ticks -> carry on every tick after the first. Phases: 0, 1, 2. frac = 99999999, 99999998, 99999997.
- Step change: run `jump`=16 for 3 ticks, then switch to `jump`=21, `remainder`=9616364.
  - `NOTE_PHASE_RESET_EN` defined: next `phase`=21.
  - Undefined: next `phase`=69.
